// File: rtl/des_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_bridge_pkg
//  Description : Shared types and sizes for the DES byte/block bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_bridge_pkg;

    localparam int BLOCK_BYTES = 8;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;

    // Bridge control states; FILL is the idle/accepting state.
    typedef enum logic [2:0] {
        FILL      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_CORE = 3'd2,
        ACK       = 3'd3,
        DRAIN     = 3'd4
    } bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_counter.sv
`default_nettype none
// ============================================================================
//  Module      : byte_counter
//  Description : 3-bit byte position counter shared by block fill and drain.
//                rollover flags the last byte of a block.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_counter (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_enable,
    output logic rollover
);

    localparam logic [2:0] c_last = 3'd7;

    logic [2:0] r_count;

    // Count accepted bytes; clear takes priority so a state entry always starts at 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= 3'd0;
        end else if (clear) begin
            r_count <= 3'd0;
        end else if (count_enable) begin
            r_count <= r_count + 3'd1;
        end
    end

    assign rollover = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/des_block_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : des_block_bridge
//  Description : Packs eight bytes into a 64-bit block for the DES core,
//                captures the processed block and streams it back out as
//                eight bytes. A stalled core is abandoned after CORE_TIMEOUT
//                cycles (0 disables the timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module des_block_bridge
    import des_bridge_pkg::*;
#(
    parameter int CORE_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [BYTE_W-1:0]  rx_byte,
    input  logic               rx_byte_valid,
    output logic               rx_byte_ready,
    output logic [BLOCK_W-1:0] rcv_data,
    output logic               rcv_data_ready,
    input  logic [BLOCK_W-1:0] trans_data,
    input  logic               trans_data_ready,
    output logic               handshake_ack,
    output logic [BYTE_W-1:0]  tx_byte,
    output logic               tx_byte_valid,
    input  logic               tx_byte_ready,
    output logic               core_timeout
);

    // A zero timeout still needs a legal one-bit counter.
    localparam int              TO_W      = (CORE_TIMEOUT > 0) ? $clog2(CORE_TIMEOUT + 1) : 1;
    localparam bit              c_to_en   = (CORE_TIMEOUT != 0);
    localparam logic [TO_W-1:0] c_to_last = (CORE_TIMEOUT > 0) ? TO_W'(CORE_TIMEOUT - 1) : '0;

    bridge_state_t        r_state;
    bridge_state_t        w_next_state;
    logic [BLOCK_W-1:0]   r_rcv_data;
    logic [BLOCK_W-1:0]   r_tx_data;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_core_timeout;
    logic                 w_rx_fire;
    logic                 w_tx_fire;
    logic                 w_capture;
    logic                 w_timeout_hit;
    logic                 w_rollover;
    logic                 w_cnt_en;
    logic                 w_cnt_clr;

    // The counter sits at CORE_TIMEOUT-1 during the CORE_TIMEOUT-th wait cycle.
    assign w_timeout_hit = c_to_en && (r_to_cnt == c_to_last);
    assign w_rx_fire     = rx_byte_valid && rx_byte_ready;
    assign w_tx_fire     = tx_byte_valid && tx_byte_ready;
    assign w_capture     = (r_state == WAIT_CORE) && trans_data_ready;

    byte_counter u_byte_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_cnt_clr),
        .count_enable (w_cnt_en),
        .rollover     (w_rollover)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a core response beats a simultaneous timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL:      if (w_rx_fire && w_rollover) w_next_state = LAUNCH;
            LAUNCH:    w_next_state = WAIT_CORE;
            WAIT_CORE: begin
                if (trans_data_ready)   w_next_state = ACK;
                else if (w_timeout_hit) w_next_state = FILL;
            end
            ACK:       w_next_state = DRAIN;
            DRAIN:     if (w_tx_fire && w_rollover) w_next_state = FILL;
            default:   w_next_state = FILL;
        endcase
    end

    // Output and counter-control decode from the registered state only.
    always_comb begin
        rx_byte_ready  = 1'b0;
        rcv_data_ready = 1'b0;
        handshake_ack  = 1'b0;
        tx_byte_valid  = 1'b0;
        case (r_state)
            FILL:    rx_byte_ready  = 1'b1;
            LAUNCH:  rcv_data_ready = 1'b1;
            ACK:     handshake_ack  = 1'b1;
            DRAIN:   tx_byte_valid  = 1'b1;
            default: ;
        endcase
        w_cnt_en  = w_rx_fire || w_tx_fire;
        w_cnt_clr = (w_next_state != r_state) &&
                    ((w_next_state == FILL) || (w_next_state == DRAIN));
    end

    // Inbound block: first byte ends up in the top byte after eight shifts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rcv_data <= '0;
        end else if (w_rx_fire) begin
            r_rcv_data <= {r_rcv_data[BLOCK_W-BYTE_W-1:0], rx_byte};
        end
    end

    // Outbound block: load on capture, then shift the sent byte out of the top.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_data <= '0;
        end else if (w_capture) begin
            r_tx_data <= trans_data;
        end else if (w_tx_fire) begin
            r_tx_data <= {r_tx_data[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        end
    end

    // Core wait timer and the registered abandon pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_to_cnt       <= '0;
            r_core_timeout <= 1'b0;
        end else begin
            r_core_timeout <= (r_state == WAIT_CORE) && !trans_data_ready && w_timeout_hit;
            if ((r_state == WAIT_CORE) && !w_timeout_hit) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign rcv_data     = r_rcv_data;
    assign tx_byte      = r_tx_data[BLOCK_W-1 -: BYTE_W];
    assign core_timeout = r_core_timeout;

endmodule
`default_nettype wire

// File: tb/tb_des_block_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_block_bridge
//  Description : Scoreboard bench for des_block_bridge (CORE_TIMEOUT = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_block_bridge;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } rcv_exp_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_byte_valid = 1'b0;
    logic        rx_byte_ready;
    logic [63:0] rcv_data;
    logic        rcv_data_ready;
    logic [63:0] trans_data = 64'h0;
    logic        trans_data_ready = 1'b0;
    logic        handshake_ack;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready = 1'b1;
    logic        core_timeout;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    rcv_exp_t    exp_rcv[$];
    logic [7:0]  exp_tx[$];
    int          exp_ack[$];
    int          exp_to[$];

    logic        stalled_prev = 1'b0;
    logic [7:0]  prev_byte = 8'h00;

    des_block_bridge #(.CORE_TIMEOUT(16)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .rx_byte          (rx_byte),
        .rx_byte_valid    (rx_byte_valid),
        .rx_byte_ready    (rx_byte_ready),
        .rcv_data         (rcv_data),
        .rcv_data_ready   (rcv_data_ready),
        .trans_data       (trans_data),
        .trans_data_ready (trans_data_ready),
        .handshake_ack    (handshake_ack),
        .tx_byte          (tx_byte),
        .tx_byte_valid    (tx_byte_valid),
        .tx_byte_ready    (tx_byte_ready),
        .core_timeout     (core_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (n_rst) begin
            if (rcv_data_ready) begin
                if (exp_rcv.size() == 0) check("rcv_pulse_spurious", 1, 0);
                else begin
                    rcv_exp_t e;
                    e = exp_rcv.pop_front();
                    check("launch_cycle", cyc, e.cyc);
                    check("rcv_data", rcv_data, e.data);
                end
            end
            if (handshake_ack) begin
                if (exp_ack.size() == 0) check("ack_spurious", 1, 0);
                else check("ack_cycle", cyc, exp_ack.pop_front());
            end
            if (core_timeout) begin
                if (exp_to.size() == 0) check("timeout_spurious", 1, 0);
                else begin
                    check("timeout_cycle", cyc, exp_to.pop_front());
                    check("ready_after_timeout", rx_byte_ready, 1);
                end
            end
            if (stalled_prev) begin
                check("tx_hold_valid", tx_byte_valid, 1);
                check("tx_hold_byte", tx_byte, prev_byte);
            end
            if (tx_byte_valid && tx_byte_ready) begin
                if (exp_tx.size() == 0) check("tx_byte_spurious", 1, 0);
                else check("tx_byte", tx_byte, exp_tx.pop_front());
            end
            stalled_prev = tx_byte_valid && !tx_byte_ready;
            prev_byte    = tx_byte;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic check_reset(input string p);
        check({p, "_rcv_data"}, rcv_data, 0);
        check({p, "_rcv_data_ready"}, rcv_data_ready, 0);
        check({p, "_handshake_ack"}, handshake_ack, 0);
        check({p, "_tx_byte"}, tx_byte, 0);
        check({p, "_tx_byte_valid"}, tx_byte_valid, 0);
        check({p, "_core_timeout"}, core_timeout, 0);
        check({p, "_rx_byte_ready"}, rx_byte_ready, 1);
    endtask

    task automatic do_reset(input string p);
        rx_byte_valid    = 1'b0;
        trans_data_ready = 1'b0;
        n_rst            = 1'b0;
        #1;
        check_reset(p);
        exp_rcv.delete();
        exp_tx.delete();
        exp_ack.delete();
        exp_to.delete();
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    // Feed the first nbytes of blk, MSB byte first; gaps = i%3 idle cycles when bursty.
    task automatic send_bytes(input logic [63:0] blk, input int nbytes, input bit bursty);
        for (int i = 0; i < nbytes; i++) begin
            rx_byte       = blk[63-8*i -: 8];
            rx_byte_valid = 1'b1;
            if (i == 7) exp_rcv.push_back('{cyc + 1, blk});
            @(posedge clk); #1;
            rx_byte_valid = 1'b0;
            if (bursty) repeat (i % 3) begin @(posedge clk); #1; end
        end
    endtask

    // Model core: answers delay cycles after the launch cycle, holds for one edge.
    task automatic core_respond(input logic [63:0] blk, input logic [63:0] cdata, input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        check("rcv_data_stable", rcv_data, blk);
        trans_data       = cdata;
        trans_data_ready = 1'b1;
        exp_ack.push_back(cyc + 1);
        for (int i = 0; i < 8; i++) exp_tx.push_back(cdata[63-8*i -: 8]);
        @(posedge clk); #1;
        trans_data_ready = 1'b0;
        trans_data       = 64'h0;
    endtask

    task automatic drain(input int stall_at, input int stall_len);
        int k;
        k = 0;
        while (exp_tx.size() != 0 && k < 64) begin
            tx_byte_ready = !(k >= stall_at && k < stall_at + stall_len);
            @(posedge clk); #1;
            k++;
        end
        tx_byte_ready = 1'b1;
        check("drain_complete", exp_tx.size(), 0);
    endtask

    initial begin
        #2;
        check_reset("reset");
        @(posedge clk); #1;
        n_rst = 1'b1;

        // Basic round trip
        send_bytes(64'h0102030405060708, 8, 1'b0);
        core_respond(64'h0102030405060708, 64'hA1A2A3A4A5A6A7A8, 3);
        drain(100, 0);

        // Stray core signal in FILL
        trans_data       = 64'h5555AAAA5555AAAA;
        trans_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stray_rx_ready", rx_byte_ready, 1);
            check("stray_no_ack", handshake_ack, 0);
            @(posedge clk); #1;
        end
        trans_data_ready = 1'b0;
        trans_data       = 64'h0;

        // Bursty input with mid-drain backpressure
        send_bytes(64'h1122334455667788, 8, 1'b1);
        core_respond(64'h1122334455667788, 64'hC0FFEE0123456789, 1);
        drain(4, 5);

        // Core never answers: abandon on the 16th wait cycle
        send_bytes(64'h2233445566778899, 8, 1'b0);
        exp_to.push_back(cyc + 17);
        repeat (20) begin @(posedge clk); #1; end

        // Capture in the same cycle the timeout is reached
        send_bytes(64'h0F1E2D3C4B5A6978, 8, 1'b0);
        core_respond(64'h0F1E2D3C4B5A6978, 64'hDEADBEEFCAFEF00D, 16);
        drain(100, 0);

        // Reset after three fill bytes, then a clean block
        send_bytes(64'hAABBCCDDEEFF0011, 3, 1'b0);
        do_reset("rst_fill");
        send_bytes(64'h8877665544332211, 8, 1'b0);
        core_respond(64'h8877665544332211, 64'h13579BDF2468ACE0, 2);
        repeat (4) begin @(posedge clk); #1; end
        do_reset("rst_drain");

        // Clean block after mid-drain reset
        send_bytes(64'hFEDCBA9876543210, 8, 1'b1);
        core_respond(64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 5);
        drain(2, 3);

        repeat (3) begin @(posedge clk); #1; end
        check("rcv_events_seen", exp_rcv.size(), 0);
        check("ack_events_seen", exp_ack.size(), 0);
        check("timeout_events_seen", exp_to.size(), 0);
        check("tx_events_seen", exp_tx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/des_block_bridge.md
# des_block_bridge

Byte-to-block bridge on the USB side of the DES encryptor core. It packs eight inbound bytes into a 64-bit block and presents it to the core with `rcv_data`/`rcv_data_ready`. It waits for `trans_data_ready`, captures `trans_data`, and answers with a one-cycle `handshake_ack`. It then serializes the processed block back out as eight bytes with a valid/ready handshake.

## Interface
- `CORE_TIMEOUT`, default 1023: maximum number of WAIT_CORE cycles before the block is abandoned. A value of 0 disables the timeout.
- `clk` input, 1 bit: system clock, rising edge.
- `n_rst` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `rx_byte` input, 8 bits: inbound byte from the USB receive path.
- `rx_byte_valid` input, 1 bit: `rx_byte` is valid this cycle.
- `rx_byte_ready` output, 1 bit: the bridge accepts a byte this cycle.
- `rcv_data` output, 64 bits: assembled block sent to the core.
- `rcv_data_ready` output, 1 bit: one-cycle launch pulse to the core.
- `trans_data` input, 64 bits: processed block from the core.
- `trans_data_ready` input, 1 bit: level signal from the core; `trans_data` is valid while it is high.
- `handshake_ack` output, 1 bit: one-cycle pulse; the core may drop `trans_data_ready`.
- `tx_byte` output, 8 bits: outbound byte.
- `tx_byte_valid` output, 1 bit: `tx_byte` is valid.
- `tx_byte_ready` input, 1 bit: the downstream consumer accepts the byte.
- `core_timeout` output, 1 bit: one-cycle pulse when a block is abandoned.

## Operation
- FSM states: FILL, LAUNCH, WAIT_CORE, ACK, DRAIN. Reset state is FILL.
- **FILL**
  - `rx_byte_ready`=1.
  - Each `rx_byte_valid && rx_byte_ready` shifts the byte into the block register. The first byte lands in `rcv_data[63:56]` and the eighth in `[7:0]` (big-endian, DES byte order).
  - The byte counter increments on each accepted byte.
  - On the 8th accept (count 7 → wrap to 0), go to LAUNCH.
- **LAUNCH**
  - `rcv_data_ready`=1 for exactly one cycle.
  - Go to WAIT_CORE.
- **WAIT_CORE**
  - Timeout counter increments every cycle.
  - If `trans_data_ready`=1, load `trans_data` into the output shift register and go to ACK.
  - Else, if `CORE_TIMEOUT`≠0 and the counter reaches `CORE_TIMEOUT`: pulse `core_timeout`, clear the counter, return to FILL, and drop the block.
- **ACK**
  - `handshake_ack`=1 for one cycle.
  - Go to DRAIN.
- **DRAIN**
  - `tx_byte_valid`=1 and `tx_byte` = output register `[63:56]`.
  - On `tx_byte_valid && tx_byte_ready`, shift left by 8 and increment the byte counter.
  - On the 8th transfer, go to FILL.
- `rcv_data` holds its value from LAUNCH until the next FILL accept, so it is stable throughout the core computation.
- `trans_data_ready` is ignored in every state except WAIT_CORE.
- `rx_byte_valid` is ignored outside FILL, where `rx_byte_ready`=0.
- No overlap: fill of the next block starts only after the drain completes.
- Simultaneous events:
  - If `trans_data_ready` rises in the same cycle the timeout is reached, capture wins and no timeout fires.
  - `tx_byte_valid` is never deasserted without a transfer.
- Reset mid-operation: all state is discarded and the FSM goes to FILL with count 0. A partially filled or draining block is lost.

## Timing
- Reset values:
  - `rcv_data`=0, `rcv_data_ready`=0, `handshake_ack`=0, `tx_byte`=0, `tx_byte_valid`=0, `core_timeout`=0.
  - `rx_byte_ready`=1 (decoded from FILL).
- All outputs are decoded from registered state or registered data. There is no combinational input-to-output path.
- 8th byte accepted at edge N: `rcv_data_ready` is high in cycle N+1.
- `trans_data_ready` sampled high at edge M:
  - `handshake_ack` is high in cycle M+1.
  - The first `tx_byte_valid` is high in cycle M+2.
- Best-case byte throughput is 1 byte/cycle in both FILL and DRAIN.
- Timeout fires on the `CORE_TIMEOUT`-th WAIT_CORE cycle.

## Structure
- Package `des_bridge_pkg` contains:
  - the state enum `bridge_state_t` (the five states above);
  - `BLOCK_BYTES`=8;
  - `BYTE_W`=8;
  - `BLOCK_W`=64.
- Sub-module `byte_counter`: 3-bit counter with `count_enable`, synchronous clear, and a `rollover` flag asserted at count 7. It is shared by FILL and DRAIN and cleared on every state entry to FILL or DRAIN.
- Timeout counter: inline, width $clog2(`CORE_TIMEOUT`+1).

## Test plan
- **Basic round trip.** Send 8 bytes 0x01…0x08 back to back, with the model core asserting `trans_data_ready` with 0xA1A2A3A4A5A6A7A8 three cycles after launch. Required: `rcv_data`=0x0102030405060708 with a one-cycle `rcv_data_ready`; `handshake_ack` one cycle after capture; `tx_byte` sequence A1…A8.
- **Bursty input and backpressure.** Insert gaps in `rx_byte_valid`, and hold `tx_byte_ready`=0 for 5 cycles mid-drain. Required: no byte lost or duplicated; `tx_byte` is stable while stalled.
- **Stray core signal.** Assert `trans_data_ready` during FILL. Required: ignored; no ack is issued and the FSM stays in FILL.
- **Timeout.** With `CORE_TIMEOUT`=16 and a core that never responds, check `core_timeout` pulses on the 16th WAIT_CORE cycle and `rx_byte_ready` returns to 1. Then assert capture and timeout in the same cycle: capture wins and no pulse occurs.
- **Reset mid-operation.** Assert `n_rst` low after 3 fill bytes and again mid-drain. Required: all outputs at reset values immediately; the next 8 bytes form a clean new block.
